control_seq: RTL and testbench



---
 rtl/control_seq_pkg.sv | 63 ++++++
 rtl/control_watchdog.sv | 40 ++++
 rtl/control_seq.sv | 218 +++++++++++++++++++++
 tb/tb_control_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/control_seq_pkg.sv
// Shared definitions for the tiny5 control sequencer: instruction classes,
// address-select encoding, trap cause codes and the FSM state/Moore types.
package control_seq_pkg;

  typedef enum logic [2:0] {
    CLASS_ALU     = 3'd0,
    CLASS_BRANCH  = 3'd1,
    CLASS_JUMP    = 3'd2,
    CLASS_SYSTEM  = 3'd3,
    CLASS_MULDIV  = 3'd4,
    CLASS_LOAD    = 3'd5,
    CLASS_STORE   = 3'd6,
    CLASS_ILLEGAL = 3'd7
  } instr_class_t;

  typedef enum logic {
    ADDR_PC  = 1'b0,
    ADDR_ALU = 1'b1
  } mem_addr_sel_t;

  localparam int CAUSE_FETCH_FAULT = 1;
  localparam int CAUSE_ILLEGAL     = 2;
  localparam int CAUSE_LOAD_FAULT  = 5;
  localparam int CAUSE_STORE_FAULT = 7;
  localparam int CAUSE_EXT_IRQ     = 11;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_FETCH_ISSUE = 3'd1,
    ST_FETCH_WAIT  = 3'd2,
    ST_DECODE      = 3'd3,
    ST_EXEC_WAIT   = 3'd4,
    ST_MEM_WAIT    = 3'd5,
    ST_TRAP        = 3'd6,
    ST_ERROR       = 3'd7
  } seq_state_t;

  // Outputs that depend on the state alone; registered from the next state.
  typedef struct packed {
    logic          pc_we;
    logic          mem_rd;
    mem_addr_sel_t addr_sel;
    logic          trap;
    logic          halted;
  } moore_out_t;

  function automatic moore_out_t moore_outputs(seq_state_t s);
    moore_out_t m;
    m = '0;
    case (s)
      ST_FETCH_ISSUE: m.mem_rd = 1'b1;
      ST_MEM_WAIT:    m.addr_sel = ADDR_ALU;
      ST_TRAP: begin
        m.pc_we = 1'b1;
        m.trap  = 1'b1;
      end
      ST_ERROR:       m.halted = 1'b1;
      default:        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/control_watchdog.sv
// Bus-timeout watchdog: counts busy cycles while a memory wait is in
// progress, saturating at LIMIT. expired_o means LIMIT busy cycles have
// already elapsed in the current wait.
module control_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_i && (count_q != LIMIT_V)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT_V);

endmodule

// File: rtl/control_seq.sv
// tiny5 multi-cycle control sequencer: fetch, decode, execute, memory access,
// precise traps, bus-timeout watchdog and double-fault halt.
// Optional feature macro: CONTROL_SEQ_IRQ_EN (external interrupt trap at
// instruction retirement). Without it irq_i/irq_enable_i are ignored.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 64,
  parameter int RESET_CYCLES = 2,
  parameter int TRAP_CAUSE_W = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [2:0]              instr_class_i,
  input  logic                    rd_we_req_i,
  input  logic                    mem_busy_i,
  input  logic                    mem_error_i,
  input  logic                    exec_busy_i,
  input  logic                    irq_i,
  input  logic                    irq_enable_i,
  output logic                    pc_we_o,
  output logic                    ir_we_o,
  output logic                    regfile_we_o,
  output logic                    mem_rd_enable_o,
  output logic                    mem_wr_enable_o,
  output logic                    mem_addr_sel_o,
  output logic                    exec_start_o,
  output logic                    pc_trap_sel_o,
  output logic                    trap_o,
  output logic [TRAP_CAUSE_W-1:0] trap_cause_o,
  output logic                    halted_o
);

  localparam int RCW    = $clog2(RESET_CYCLES + 1);
  localparam int CODE_W = TRAP_CAUSE_W - 1;
  localparam logic [RCW-1:0] RESET_LOAD = RCW'(RESET_CYCLES - 1);

  localparam logic [TRAP_CAUSE_W-1:0] C_FETCH = {1'b0, CODE_W'(CAUSE_FETCH_FAULT)};
  localparam logic [TRAP_CAUSE_W-1:0] C_ILL   = {1'b0, CODE_W'(CAUSE_ILLEGAL)};
  localparam logic [TRAP_CAUSE_W-1:0] C_LOAD  = {1'b0, CODE_W'(CAUSE_LOAD_FAULT)};
  localparam logic [TRAP_CAUSE_W-1:0] C_STORE = {1'b0, CODE_W'(CAUSE_STORE_FAULT)};
  localparam logic [TRAP_CAUSE_W-1:0] C_IRQ   = {1'b1, CODE_W'(CAUSE_EXT_IRQ)};

  seq_state_t              state_q, state_d;
  logic [RCW-1:0]          rst_cnt_q;
  logic [TRAP_CAUSE_W-1:0] cause_q, cause_d;
  logic                    in_trap_fetch_q;
  logic                    exec_skip_q;
  logic                    is_store_q, is_store_d;
  moore_out_t              moore_q;

  instr_class_t cls;
  logic         in_mem_wait;
  logic         wd_expired;
  logic         mem_fault;
  logic         irq_take;
  logic         retire;
  logic         pc_we_c, ir_we_c, rf_we_c, rd_c, wr_c, sel_c, start_c;

  assign cls         = instr_class_t'(instr_class_i);
  assign in_mem_wait = (state_q == ST_FETCH_WAIT) || (state_q == ST_MEM_WAIT);

  // Cleared whenever we are outside a wait state, so every wait starts at 0.
  control_watchdog #(
    .LIMIT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (!in_mem_wait),
    .count_i   (mem_busy_i),
    .expired_o (wd_expired)
  );

  // Error and timeout are indistinguishable; both beat completion.
  assign mem_fault = mem_error_i | (mem_busy_i & wd_expired);

`ifdef CONTROL_SEQ_IRQ_EN
  assign irq_take = irq_i & irq_enable_i;
`else
  logic unused_irq;
  assign unused_irq = irq_i ^ irq_enable_i;
  assign irq_take   = 1'b0;
`endif

  // Next-state, trap cause selection and input-dependent enables.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    is_store_d = is_store_q;
    retire     = 1'b0;
    pc_we_c    = 1'b0;
    ir_we_c    = 1'b0;
    rf_we_c    = 1'b0;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    sel_c      = 1'b0;
    start_c    = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == '0) state_d = ST_FETCH_ISSUE;
      end
      ST_FETCH_ISSUE: state_d = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        if (mem_fault) begin
          if (in_trap_fetch_q) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_TRAP;
            cause_d = C_FETCH;
          end
        end else if (!mem_busy_i) begin
          ir_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLASS_MULDIV: begin
            start_c = 1'b1;
            state_d = ST_EXEC_WAIT;
          end
          CLASS_LOAD: begin
            rd_c       = 1'b1;
            sel_c      = 1'b1;
            is_store_d = 1'b0;
            state_d    = ST_MEM_WAIT;
          end
          CLASS_STORE: begin
            wr_c       = 1'b1;
            sel_c      = 1'b1;
            is_store_d = 1'b1;
            state_d    = ST_MEM_WAIT;
          end
          CLASS_ILLEGAL: begin
            state_d = ST_TRAP;
            cause_d = C_ILL;
          end
          default: begin
            rf_we_c = rd_we_req_i;
            pc_we_c = 1'b1;
            retire  = 1'b1;
          end
        endcase
      end
      ST_EXEC_WAIT: begin
        // The first cycle after the start pulse is skipped: busy is not yet valid.
        if (!exec_skip_q && !exec_busy_i) begin
          rf_we_c = rd_we_req_i;
          pc_we_c = 1'b1;
          retire  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        sel_c = 1'b1;
        if (mem_fault) begin
          state_d = ST_TRAP;
          cause_d = is_store_q ? C_STORE : C_LOAD;
        end else if (!mem_busy_i) begin
          rf_we_c = !is_store_q && rd_we_req_i;
          pc_we_c = 1'b1;
          retire  = 1'b1;
        end
      end
      ST_TRAP:  state_d = ST_FETCH_ISSUE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
    // Retirement: writes above still happen; a pending interrupt redirects to TRAP.
    if (retire) begin
      if (irq_take) begin
        state_d = ST_TRAP;
        cause_d = C_IRQ;
      end else begin
        state_d = ST_FETCH_ISSUE;
      end
    end
  end

  // FSM state, bookkeeping flags and registered Moore outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_RESET;
      rst_cnt_q       <= RESET_LOAD;
      cause_q         <= '0;
      in_trap_fetch_q <= 1'b0;
      exec_skip_q     <= 1'b0;
      is_store_q      <= 1'b0;
      moore_q         <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      is_store_q  <= is_store_d;
      moore_q     <= moore_outputs(state_d);
      exec_skip_q <= (state_q == ST_DECODE) && (state_d == ST_EXEC_WAIT);
      if ((state_q == ST_RESET) && (rst_cnt_q != '0)) begin
        rst_cnt_q <= rst_cnt_q - RCW'(1);
      end
      if (state_q == ST_TRAP) begin
        in_trap_fetch_q <= 1'b1;
      end else if (ir_we_c) begin
        in_trap_fetch_q <= 1'b0;
      end
    end
  end

  assign pc_we_o         = moore_q.pc_we | pc_we_c;
  assign ir_we_o         = ir_we_c;
  assign regfile_we_o    = rf_we_c;
  assign mem_rd_enable_o = moore_q.mem_rd | rd_c;
  assign mem_wr_enable_o = wr_c;
  assign mem_addr_sel_o  = (moore_q.addr_sel == ADDR_ALU) | sel_c;
  assign exec_start_o    = start_c;
  assign pc_trap_sel_o   = moore_q.trap;
  assign trap_o          = moore_q.trap;
  assign trap_cause_o    = cause_q;
  assign halted_o        = moore_q.halted;

endmodule

// File: tb/tb_control_seq.sv
// Directed scoreboard bench for control_seq (MEM_TIMEOUT=8, RESET_CYCLES=2).
// Expected output vectors are queued as each cycle's stimulus is driven and
// popped/compared on the falling edge of that cycle.
module tb_control_seq;
  import control_seq_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [2:0] instr_class_i;
  logic       rd_we_req_i, mem_busy_i, mem_error_i, exec_busy_i, irq_i, irq_enable_i;
  logic       pc_we_o, ir_we_o, regfile_we_o, mem_rd_enable_o, mem_wr_enable_o;
  logic       mem_addr_sel_o, exec_start_o, pc_trap_sel_o, trap_o, halted_o;
  logic [4:0] trap_cause_o;

  control_seq #(
    .MEM_TIMEOUT (8),
    .RESET_CYCLES(2),
    .TRAP_CAUSE_W(5)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .instr_class_i  (instr_class_i),
    .rd_we_req_i    (rd_we_req_i),
    .mem_busy_i     (mem_busy_i),
    .mem_error_i    (mem_error_i),
    .exec_busy_i    (exec_busy_i),
    .irq_i          (irq_i),
    .irq_enable_i   (irq_enable_i),
    .pc_we_o        (pc_we_o),
    .ir_we_o        (ir_we_o),
    .regfile_we_o   (regfile_we_o),
    .mem_rd_enable_o(mem_rd_enable_o),
    .mem_wr_enable_o(mem_wr_enable_o),
    .mem_addr_sel_o (mem_addr_sel_o),
    .exec_start_o   (exec_start_o),
    .pc_trap_sel_o  (pc_trap_sel_o),
    .trap_o         (trap_o),
    .trap_cause_o   (trap_cause_o),
    .halted_o       (halted_o)
  );

  always #5 clk_i = ~clk_i;

  // Output flag positions within the expected vector (cause occupies [4:0]).
  localparam logic [9:0] PC   = 10'b10_0000_0000;
  localparam logic [9:0] IR   = 10'b01_0000_0000;
  localparam logic [9:0] RF   = 10'b00_1000_0000;
  localparam logic [9:0] RD   = 10'b00_0100_0000;
  localparam logic [9:0] WR   = 10'b00_0010_0000;
  localparam logic [9:0] SEL  = 10'b00_0001_0000;
  localparam logic [9:0] ST   = 10'b00_0000_1000;
  localparam logic [9:0] TSEL = 10'b00_0000_0100;
  localparam logic [9:0] TRAP = 10'b00_0000_0010;
  localparam logic [9:0] HALT = 10'b00_0000_0001;

  int          checks = 0;
  int          errors = 0;
  logic [14:0] exp_q[$];
  string       tag_q[$];
  logic [4:0]  cur_cause;
  logic [14:0] obs;

  assign obs = {pc_we_o, ir_we_o, regfile_we_o, mem_rd_enable_o, mem_wr_enable_o,
                mem_addr_sel_o, exec_start_o, pc_trap_sel_o, trap_o, halted_o, trap_cause_o};

  // One clock cycle: queue the expectation, compare mid-cycle, advance.
  task automatic step(input string tag, input logic [9:0] flags);
    logic [14:0] e;
    string       t;
    exp_q.push_back({flags, cur_cause});
    tag_q.push_back(tag);
    @(negedge clk_i);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic trap_step(input string tag, input logic [4:0] cause);
    cur_cause = cause;
    step(tag, PC | TSEL | TRAP);
  endtask

  // FETCH_ISSUE, nbusy busy wait cycles, then the completing cycle.
  task automatic fetch(input string tag, input int nbusy);
    mem_busy_i = 1'b0;
    step({tag, "_issue"}, RD);
    mem_busy_i = 1'b1;
    for (int i = 0; i < nbusy; i++) step({tag, "_wait"}, '0);
    mem_busy_i = 1'b0;
    step({tag, "_ir"}, IR);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    reset_i = 1'b1;
    instr_class_i = CLASS_ALU;
    rd_we_req_i = 1'b0; mem_busy_i = 1'b0; mem_error_i = 1'b0;
    exec_busy_i = 1'b0; irq_i = 1'b0; irq_enable_i = 1'b0;
    cur_cause = 5'd0;
    @(posedge clk_i); #1;
    step("reset_hold", '0);
    reset_i = 1'b0;
    step("reset_cnt1", '0);
    step("reset_cnt0", '0);

    // ALU: busy one cycle after issue, IR written on the third cycle.
    fetch("alu", 1);
    instr_class_i = CLASS_ALU; rd_we_req_i = 1'b1;
    step("alu_dec", PC | RF);

    // LOAD with five busy cycles: ALU address select throughout.
    fetch("load", 0);
    instr_class_i = CLASS_LOAD;
    step("load_dec", RD | SEL);
    mem_busy_i = 1'b1;
    repeat (5) step("load_wait", SEL);
    mem_busy_i = 1'b0;
    step("load_done", PC | RF | SEL);

    // STORE: error together with busy low traps with cause 7, no writes.
    fetch("store", 0);
    instr_class_i = CLASS_STORE;
    step("store_dec", WR | SEL);
    mem_error_i = 1'b1;
    step("store_err", SEL);
    mem_error_i = 1'b0;
    trap_step("store_trap", 5'd7);
    fetch("post_store", 0);

    // MULDIV: start pulse, ignored first cycle, 32 busy cycles, no watchdog.
    instr_class_i = CLASS_MULDIV;
    step("mul_dec", ST);
    exec_busy_i = 1'b0;
    step("mul_skip", '0);
    exec_busy_i = 1'b1; mem_busy_i = 1'b1;
    repeat (32) step("mul_wait", '0);
    exec_busy_i = 1'b0; mem_busy_i = 1'b0;
    step("mul_done", PC | RF);

    // ILLEGAL traps with cause 2; the following fetch sits exactly at the
    // timeout boundary (8 busy cycles, then ready) and must not fault.
    fetch("ill", 0);
    instr_class_i = CLASS_ILLEGAL;
    step("ill_dec", '0);
    trap_step("ill_trap", 5'd2);
    fetch("edge8", 8);
    instr_class_i = CLASS_ALU; rd_we_req_i = 1'b0;
    step("alu_norf", PC);

    // Stuck fetch: the ninth consecutive busy cycle is the fault decision.
    step("to_issue", RD);
    mem_busy_i = 1'b1;
    repeat (9) step("to_wait", '0);
    trap_step("to_trap", 5'd1);
    step("df_issue", RD);
    repeat (9) step("df_wait", '0);
    repeat (3) step("halt", HALT);
    mem_busy_i = 1'b0; mem_error_i = 1'b1;
    step("halt_err", HALT);
    mem_error_i = 1'b0;
    reset_i = 1'b1;
    step("halt_in_reset", HALT);
    reset_i = 1'b0;
    cur_cause = 5'd0;
    step("post_reset1", '0);
    step("post_reset0", '0);

    // Interrupt at ALU retirement, then with the enable cleared.
    fetch("irq", 0);
    irq_i = 1'b1; irq_enable_i = 1'b1; instr_class_i = CLASS_ALU; rd_we_req_i = 1'b1;
    step("irq_dec", PC | RF);
`ifdef CONTROL_SEQ_IRQ_EN
    trap_step("irq_trap", 5'b1_1011);
`endif
    fetch("irq_off", 0);
    irq_enable_i = 1'b0;
    step("irq_off_dec", PC | RF);
    irq_i = 1'b0;

    // Bus error on the first fetch after a trap is a double fault.
    fetch("ill2", 0);
    instr_class_i = CLASS_ILLEGAL;
    step("ill2_dec", '0);
    trap_step("ill2_trap", 5'd2);
    step("ef_issue", RD);
    mem_error_i = 1'b1;
    step("ef_err", '0);
    mem_error_i = 1'b0;
    step("ef_halt", HALT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
